change_dispenser: RTL and testbench
===================================

// Module: change_dispenser
// PURPOSE
//  Coin-out side of the vending controller. Takes a change amount in cents and
//  drives the coin hopper with one-cycle quarter/dime/nickel pulses, using
//  greedy largest-coin-first selection and a programmable recovery gap between
//  coins. Shows the remaining change as two BCD digits for the OLED path.
// PARAMETERS
//  MAX_CENTS   95  largest accepted change amount; must be a multiple of 5, <=95
//  GAP_CYCLES  1   idle cycles after each coin pulse (hopper recovery), 0..15
//  Q_STOCK     8   initial quarter count (used only when COIN_INVENTORY_EN is defined)
//  D_STOCK     8   initial dime count (used only when COIN_INVENTORY_EN is defined)
//  N_STOCK     8   initial nickel count (used only when COIN_INVENTORY_EN is defined)
// PORTS
//  clk             in   1  system clock, rising edge
//  reset           in   1  synchronous, active-high reset
//  i_start         in   1  request to dispense i_change_cents; sampled only in IDLE
//  i_change_cents  in   7  change amount in cents
//  i_refill        in   1  restock pulse (effective only with COIN_INVENTORY_EN)
//  o_quarter       out  1  one-cycle pulse: eject one quarter
//  o_dime          out  1  one-cycle pulse: eject one dime
//  o_nickel        out  1  one-cycle pulse: eject one nickel
//  o_busy          out  1  high from the accepted start until done or error
//  o_done          out  1  one-cycle pulse: all change paid
//  o_error         out  1  one-cycle pulse: request rejected or change cannot be paid
//  o_changeMSB     out  4  BCD tens digit of the remaining change
//  o_changeLSB     out  4  BCD units digit of the remaining change (0 or 5)
// BEHAVIOUR
//  - Reset: state IDLE, remaining change 0, every output 0; the gap counter clears.
//    Reset during dispensing aborts the job. No further coin pulses are issued.
//  - All outputs are registered except o_changeMSB/LSB, which decode the
//    remaining-change register combinationally.
//  - States:
//    - IDLE: wait for a request.
//    - DISPENSE: choose and eject coins.
//    - GAP: recovery delay after each coin.
//  - IDLE, at an edge with i_start=1:
//    - If i_change_cents%5!=0 or i_change_cents>MAX_CENTS: pulse o_error and stay IDLE.
//    - Otherwise load the remaining-change register, set o_busy=1 and go to DISPENSE.
//  - DISPENSE, at each edge:
//    - If remaining>=25, pulse o_quarter and subtract 25.
//    - Else if remaining>=10, pulse o_dime and subtract 10.
//    - Else if remaining>=5, pulse o_nickel and subtract 5.
//    - After a coin: load the gap counter with GAP_CYCLES and go to GAP. If GAP_CYCLES=0, stay in DISPENSE.
//    - If remaining==0: pulse o_done, clear o_busy, go to IDLE.
//  - GAP: decrement the counter at each edge; when it reaches 0, return to DISPENSE.
//  - At most one coin output is high in any cycle. Consecutive coin pulses are
//    GAP_CYCLES+1 cycles apart.
//  - i_start while busy is ignored and not queued. A zero-cent request gives o_done one cycle after o_busy rises.
//  - The remaining-change register is never negative and never exceeds MAX_CENTS.
// CONFIGURATION
//  COIN_INVENTORY_EN defined:
//    - Per-coin stock counters load Q/D/N_STOCK at reset, and again on an i_refill
//      pulse taken in IDLE.
//    - Each coin pulse decrements its counter.
//    - Selection skips a coin whose stock is 0 and falls back to the next smaller coin.
//    - If remaining>0 and no usable coin exists: pulse o_error, clear o_busy, go to
//      IDLE. The unpaid amount stays on o_changeMSB/LSB until the next accepted start.
//  COIN_INVENTORY_EN undefined: unlimited stock, i_refill ignored, no stock counters,
//    and o_error is raised only for rejected requests.
// TESTING
//  1. GAP_CYCLES=1, start with 40 at edge 0 -> o_busy from edge 0; quarter at edge 1,
//     dime at edge 3, nickel at edge 5; o_done at edge 7, o_busy low.
//  2. Start with 95 -> Q,Q,Q,D,D in that order; digits step 9/5, 7/0, 4/5, 2/0, 1/0, 0/0.
//  3. Start with 37, then 100 -> o_error pulse each time; no coin pulses; o_busy stays 0.
//  4. Reset asserted two cycles into a 75-cent job -> all outputs 0 next edge;
//     no further coins; digits read 0/0.
//  5. i_start pulsed during a busy 50-cent job -> ignored; exactly Q,Q, then o_done.
//  6. COIN_INVENTORY_EN, Q_STOCK=0, N_STOCK=1, request 30 -> D,D,D, o_done; then
//     D_STOCK exhausted, request 15 -> N, then o_error with digits 1/0; i_refill restores stock.

Source files
------------

// File: rtl/change_dispenser.sv
`default_nettype none
// ============================================================================
// Module   : change_dispenser
// Purpose  : Pays a change amount as greedy quarter/dime/nickel hopper pulses,
//            with a recovery gap after each coin. Shows the remaining change as
//            two BCD digits. Optional macro COIN_INVENTORY_EN adds per-coin
//            stock counters with refill and fallback to smaller coins.
// Revision : 1.0 - initial release
// ============================================================================
module change_dispenser #(
  parameter int MAX_CENTS  = 95,
  parameter int GAP_CYCLES = 1,
  parameter int Q_STOCK    = 8,
  parameter int D_STOCK    = 8,
  parameter int N_STOCK    = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_start,
  input  logic [6:0] i_change_cents,
  input  logic       i_refill,
  output logic       o_quarter,
  output logic       o_dime,
  output logic       o_nickel,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_error,
  output logic [3:0] o_changeMSB,
  output logic [3:0] o_changeLSB
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DISPENSE = 2'd1,
    S_GAP      = 2'd2
  } state_t;

  localparam logic [6:0] c_max_cents = 7'(MAX_CENTS);
  localparam logic [3:0] c_gap       = 4'(GAP_CYCLES);

  state_t     r_state;
  logic [6:0] r_rem;
  logic [3:0] r_gap;

  logic w_bad_req;
  logic w_q_ok;
  logic w_d_ok;
  logic w_n_ok;

  assign w_bad_req = ((i_change_cents % 7'd5) != 7'd0) || (i_change_cents > c_max_cents);

`ifdef COIN_INVENTORY_EN
  logic [7:0] r_q_stk;
  logic [7:0] r_d_stk;
  logic [7:0] r_n_stk;

  assign w_q_ok = (r_rem >= 7'd25) && (r_q_stk != 8'd0);
  assign w_d_ok = (r_rem >= 7'd10) && (r_d_stk != 8'd0);
  assign w_n_ok = (r_rem >= 7'd5)  && (r_n_stk != 8'd0);
`else
  logic w_unused_cfg;
  assign w_unused_cfg = i_refill | ((Q_STOCK + D_STOCK + N_STOCK) == 0);

  assign w_q_ok = (r_rem >= 7'd25);
  assign w_d_ok = (r_rem >= 7'd10);
  assign w_n_ok = (r_rem >= 7'd5);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_rem     <= 7'd0;
      r_gap     <= 4'd0;
      o_quarter <= 1'b0;
      o_dime    <= 1'b0;
      o_nickel  <= 1'b0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_error   <= 1'b0;
`ifdef COIN_INVENTORY_EN
      r_q_stk   <= 8'(Q_STOCK);
      r_d_stk   <= 8'(D_STOCK);
      r_n_stk   <= 8'(N_STOCK);
`endif
    end else begin
      o_quarter <= 1'b0;
      o_dime    <= 1'b0;
      o_nickel  <= 1'b0;
      o_done    <= 1'b0;
      o_error   <= 1'b0;
      case (r_state)
        S_IDLE: begin
`ifdef COIN_INVENTORY_EN
          if (i_refill) begin
            r_q_stk <= 8'(Q_STOCK);
            r_d_stk <= 8'(D_STOCK);
            r_n_stk <= 8'(N_STOCK);
          end
`endif
          if (i_start) begin
            if (w_bad_req) begin
              o_error <= 1'b1;
            end else begin
              r_rem   <= i_change_cents;
              o_busy  <= 1'b1;
              r_state <= S_DISPENSE;
            end
          end
        end
        S_DISPENSE: begin
          if (r_rem == 7'd0) begin
            o_done  <= 1'b1;
            o_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (w_q_ok || w_d_ok || w_n_ok) begin
            if (w_q_ok) begin
              o_quarter <= 1'b1;
              r_rem     <= r_rem - 7'd25;
`ifdef COIN_INVENTORY_EN
              r_q_stk   <= r_q_stk - 8'd1;
`endif
            end else if (w_d_ok) begin
              o_dime  <= 1'b1;
              r_rem   <= r_rem - 7'd10;
`ifdef COIN_INVENTORY_EN
              r_d_stk <= r_d_stk - 8'd1;
`endif
            end else begin
              o_nickel <= 1'b1;
              r_rem    <= r_rem - 7'd5;
`ifdef COIN_INVENTORY_EN
              r_n_stk  <= r_n_stk - 8'd1;
`endif
            end
            // With no recovery gap the next coin is chosen on the very next edge.
            if (GAP_CYCLES != 0) begin
              r_gap   <= c_gap;
              r_state <= S_GAP;
            end
          end else begin
            // Unpayable remainder is left in r_rem so the display keeps showing it.
            o_error <= 1'b1;
            o_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_GAP: begin
          r_gap <= r_gap - 4'd1;
          if (r_gap <= 4'd1) begin
            r_state <= S_DISPENSE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_changeMSB = 4'(r_rem / 7'd10);
  assign o_changeLSB = 4'(r_rem % 7'd10);

endmodule
`default_nettype wire

// File: tb/tb_change_dispenser.sv
`default_nettype none
// ============================================================================
// Module   : tb_change_dispenser
// Purpose  : Directed and random jobs for change_dispenser, checked against a
//            cycle-timeline reference built from greedy coin arithmetic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_change_dispenser;

  localparam int GAP  = 1;
  localparam int MAXC = 95;
  localparam int QS   = 0;
  localparam int DS   = 3;
  localparam int NS   = 1;

  logic       clk = 1'b0;
  logic       reset;
  logic       i_start;
  logic [6:0] i_change_cents;
  logic       i_refill;
  logic       o_quarter, o_dime, o_nickel, o_busy, o_done, o_error;
  logic [3:0] o_changeMSB, o_changeLSB;

  change_dispenser #(
    .MAX_CENTS (MAXC),
    .GAP_CYCLES(GAP),
    .Q_STOCK   (QS),
    .D_STOCK   (DS),
    .N_STOCK   (NS)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .i_start       (i_start),
    .i_change_cents(i_change_cents),
    .i_refill      (i_refill),
    .o_quarter     (o_quarter),
    .o_dime        (o_dime),
    .o_nickel      (o_nickel),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_error       (o_error),
    .o_changeMSB   (o_changeMSB),
    .o_changeLSB   (o_changeLSB)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Reference state: amount shown on the display and coins left in the hopper.
  int m_rem = 0;
  int sq, sd, sn;
  logic [13:0] exp_q[$];

  logic [13:0] obs;
  assign obs = {o_quarter, o_dime, o_nickel, o_busy, o_done, o_error, o_changeMSB, o_changeLSB};

  function automatic logic [13:0] pack(bit q, bit d, bit n, bit busy, bit done, bit err, int rem);
    return {q, d, n, busy, done, err, 4'(rem / 10), 4'(rem % 10)};
  endfunction

  task automatic check(string tag, logic [13:0] e);
    n_checks++;
    assert (obs === e) else begin
      n_err++;
      $error("FAIL %s got{q,d,n,busy,done,err,msb,lsb}=%b exp=%b", tag, obs, e);
    end
  endtask

  task automatic model_restock();
`ifdef COIN_INVENTORY_EN
    sq = QS; sd = DS; sn = NS;
`else
    sq = 100000; sd = 100000; sn = 100000;
`endif
  endtask

  // Expected outputs after each edge, starting at the edge that takes i_start.
  task automatic plan(int amt);
    int rem;
    exp_q.delete();
    if ((amt % 5) != 0 || amt > MAXC) begin
      exp_q.push_back(pack(0, 0, 0, 0, 0, 1, m_rem));
    end else begin
      rem = amt;
      exp_q.push_back(pack(0, 0, 0, 1, 0, 0, rem));
      while (rem > 0) begin
        if (rem >= 25 && sq > 0) begin
          sq--; rem -= 25; exp_q.push_back(pack(1, 0, 0, 1, 0, 0, rem));
        end else if (rem >= 10 && sd > 0) begin
          sd--; rem -= 10; exp_q.push_back(pack(0, 1, 0, 1, 0, 0, rem));
        end else if (rem >= 5 && sn > 0) begin
          sn--; rem -= 5;  exp_q.push_back(pack(0, 0, 1, 1, 0, 0, rem));
        end else begin
          break;
        end
        repeat (GAP) exp_q.push_back(pack(0, 0, 0, 1, 0, 0, rem));
      end
      exp_q.push_back(pack(0, 0, 0, 0, rem == 0, rem != 0, rem));
      m_rem = rem;
    end
    exp_q.push_back(pack(0, 0, 0, 0, 0, 0, m_rem));
  endtask

  task automatic run_job(int amt, bit poke_en);
    int last_busy;
    int poke;
    plan(amt);
    last_busy = exp_q.size() - 2;
    poke = (poke_en && last_busy >= 1) ? int'($urandom_range(1, last_busy)) : -1;
    @(negedge clk);
    i_start = 1'b1;
    i_change_cents = 7'(amt);
    for (int t = 0; t < exp_q.size(); t++) begin
      if (t > 0) begin
        @(negedge clk);
        i_start = (t == poke);
        i_change_cents = 7'($urandom_range(0, 127));
      end
      @(posedge clk);
      #1;
      check($sformatf("job%0d_t%0d", amt, t), exp_q[t]);
    end
    i_start = 1'b0;
  endtask

  task automatic do_refill();
    @(negedge clk);
    i_refill = 1'b1;
    @(posedge clk);
    #1;
    check("refill_idle", pack(0, 0, 0, 0, 0, 0, m_rem));
`ifdef COIN_INVENTORY_EN
    model_restock();
`endif
    i_refill = 1'b0;
  endtask

  initial begin
    int amt;
    reset = 1'b1;
    i_start = 1'b0;
    i_change_cents = 7'd0;
    i_refill = 1'b0;
    model_restock();
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", pack(0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    reset = 1'b0;

    run_job(40, 1'b0);
    run_job(95, 1'b0);
    run_job(37, 1'b0);
    run_job(100, 1'b0);
    run_job(0, 1'b0);
    run_job(50, 1'b1);
    run_job(95, 1'b1);

    // Reset two edges into a 75-cent job aborts it.
    plan(75);
    @(negedge clk);
    i_start = 1'b1;
    i_change_cents = 7'd75;
    @(posedge clk); #1;
    check("rst_job_t0", exp_q[0]);
    @(negedge clk);
    i_start = 1'b0;
    @(posedge clk); #1;
    check("rst_job_t1", exp_q[1]);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    m_rem = 0;
    model_restock();
    check("rst_abort", pack(0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check($sformatf("rst_quiet%0d", k), pack(0, 0, 0, 0, 0, 0, 0));
    end

    // Stock exhaustion path (fallback and error in the inventory build).
    run_job(30, 1'b0);
    run_job(15, 1'b0);
    run_job(105, 1'b0);
    do_refill();
    run_job(15, 1'b0);

    for (int k = 0; k < 30; k++) begin
      if ($urandom_range(0, 3) == 0) amt = int'($urandom_range(0, 127));
      else amt = 5 * int'($urandom_range(0, 19));
      if ($urandom_range(0, 3) == 0) do_refill();
      run_job(amt, 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
